// File: rtl/hand_signal_encoder_if.sv
// Frame-result inputs and gesture-code outputs of hand_signal_encoder, bundled with
// master (hand-detection side) and slave (encoder side) modports.
interface hand_signal_encoder_if #(
  parameter int X_WIDTH = 11,
  parameter int Y_WIDTH = 10
);
  // frame_done_in is a one-cycle valid with no ready: the encoder takes it only when idle,
  // otherwise it is dropped and overrun_out latches. new_data_out is a one-cycle valid for
  // data_out with no back-pressure; the consumer must take it in that cycle.
  logic               frame_done_in;
  logic               hand_valid_in;
  logic [X_WIDTH-1:0] hand_x_in;
  logic [Y_WIDTH-1:0] hand_y_in;
  logic               hand_closed_in;
  logic               new_data_out;
  logic [3:0]         data_out;
  logic               overrun_out;

  modport master (
    output frame_done_in, hand_valid_in, hand_x_in, hand_y_in, hand_closed_in,
    input  new_data_out, data_out, overrun_out
  );

  modport slave (
    input  frame_done_in, hand_valid_in, hand_x_in, hand_y_in, hand_closed_in,
    output new_data_out, data_out, overrun_out
  );
endinterface

// File: rtl/hand_signal_encoder.sv
// Turns per-frame hand centroid / fist state into strobed 4-bit gesture codes.
// Optional emit counter port is enabled by defining HAND_SIGNAL_ENCODER_EMIT_COUNT_EN.
module hand_signal_encoder #(
  parameter int X_WIDTH       = 11,
  parameter int Y_WIDTH       = 10,
  parameter int DEAD_ZONE     = 16,
  parameter int CLOSE_FRAMES  = 8,
  parameter int REPEAT_FRAMES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  hand_signal_encoder_if.slave bus,
  output logic [1:0]           state_dbg_out
`ifdef HAND_SIGNAL_ENCODER_EMIT_COUNT_EN
  ,
  output logic [15:0]          emit_count_out
`endif
);

  localparam int AW = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 1;
  localparam int CW = $clog2(CLOSE_FRAMES + 1);
  localparam int RW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

  localparam logic [3:0] C_IDLE   = 4'd0;
  localparam logic [3:0] C_UP     = 4'd1;
  localparam logic [3:0] C_DOWN   = 4'd2;
  localparam logic [3:0] C_LEFT   = 4'd3;
  localparam logic [3:0] C_RIGHT  = 4'd4;
  localparam logic [3:0] C_FILTER = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t             state_q;
  logic [X_WIDTH-1:0] x_q, anchor_x_q;
  logic [Y_WIDTH-1:0] y_q, anchor_y_q;
  logic               valid_q, closed_q, anchor_vld_q;
  logic [CW-1:0]      closed_cnt_q;
  logic [RW-1:0]      rep_cnt_q;
  logic [3:0]         last_code_q;
  logic               new_data_q, overrun_q;
  logic [3:0]         data_q;

  logic signed [X_WIDTH:0] dx_c;
  logic signed [Y_WIDTH:0] dy_c;
  logic [AW-1:0]           adx_c, ady_c;
  logic                    in_dz_c;
  logic [3:0]              dir_c;

  logic          emit_d;
  logic [3:0]    code_d;
  logic [CW-1:0] closed_cnt_d;
  logic [RW-1:0] rep_cnt_d;
  logic          anchor_vld_d;

  // Differences are taken one bit wider than the coordinates so they never wrap.
  always_comb begin
    dx_c    = $signed({1'b0, x_q}) - $signed({1'b0, anchor_x_q});
    dy_c    = $signed({1'b0, y_q}) - $signed({1'b0, anchor_y_q});
    adx_c   = dx_c[X_WIDTH] ? AW'(-dx_c) : AW'(dx_c);
    ady_c   = dy_c[Y_WIDTH] ? AW'(-dy_c) : AW'(dy_c);
    in_dz_c = (adx_c <= AW'(DEAD_ZONE)) && (ady_c <= AW'(DEAD_ZONE));
    if (adx_c >= ady_c) dir_c = dx_c[X_WIDTH] ? C_LEFT : C_RIGHT;
    else                dir_c = dy_c[Y_WIDTH] ? C_UP   : C_DOWN;
  end

  always_comb begin
    emit_d       = 1'b0;
    code_d       = C_IDLE;
    closed_cnt_d = closed_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    anchor_vld_d = anchor_vld_q;
    if (!valid_q) begin
      anchor_vld_d = 1'b0;
      closed_cnt_d = '0;
      rep_cnt_d    = '0;
      emit_d       = (last_code_q != C_IDLE);
    end else if (!anchor_vld_q) begin
      anchor_vld_d = 1'b1;
    end else if (closed_q) begin
      code_d = C_FILTER;
      if (closed_cnt_q != CW'(CLOSE_FRAMES)) begin
        closed_cnt_d = closed_cnt_q + 1'b1;
        emit_d       = (closed_cnt_q == CW'(CLOSE_FRAMES - 1));
      end
    end else if (closed_cnt_q != '0) begin
      // The decoder needs a non-filter code between two filter changes.
      closed_cnt_d = '0;
      emit_d       = (last_code_q == C_FILTER);
    end else if (in_dz_c) begin
      rep_cnt_d = '0;
      emit_d    = (last_code_q >= C_UP) && (last_code_q <= C_RIGHT);
    end else begin
      code_d = dir_c;
      if ((dir_c != last_code_q) || (rep_cnt_q == '0)) begin
        emit_d    = 1'b1;
        rep_cnt_d = RW'(REPEAT_FRAMES - 1);
      end else begin
        rep_cnt_d = rep_cnt_q - 1'b1;
      end
    end
  end

  // The decision is registered on the CALC->EMIT edge so the strobe is live during S_EMIT.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      valid_q      <= 1'b0;
      closed_q     <= 1'b0;
      anchor_x_q   <= '0;
      anchor_y_q   <= '0;
      anchor_vld_q <= 1'b0;
      closed_cnt_q <= '0;
      rep_cnt_q    <= '0;
      last_code_q  <= C_IDLE;
      new_data_q   <= 1'b0;
      data_q       <= C_IDLE;
      overrun_q    <= 1'b0;
    end else begin
      new_data_q <= 1'b0;
      if (bus.frame_done_in && (state_q != S_IDLE)) overrun_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (bus.frame_done_in) begin
            x_q      <= bus.hand_x_in;
            y_q      <= bus.hand_y_in;
            valid_q  <= bus.hand_valid_in;
            closed_q <= bus.hand_closed_in;
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          closed_cnt_q <= closed_cnt_d;
          rep_cnt_q    <= rep_cnt_d;
          anchor_vld_q <= anchor_vld_d;
          if (valid_q && !anchor_vld_q) begin
            anchor_x_q <= x_q;
            anchor_y_q <= y_q;
          end
          if (emit_d) begin
            new_data_q  <= 1'b1;
            data_q      <= code_d;
            last_code_q <= code_d;
          end
          state_q <= S_EMIT;
        end
        S_EMIT:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef HAND_SIGNAL_ENCODER_EMIT_COUNT_EN
  logic [15:0] emit_count_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in)                          emit_count_q <= '0;
    else if ((state_q == S_CALC) && emit_d) emit_count_q <= emit_count_q + 16'd1;
  end

  assign emit_count_out = emit_count_q;
`endif

  assign bus.new_data_out = new_data_q;
  assign bus.data_out     = data_q;
  assign bus.overrun_out  = overrun_q;
  assign state_dbg_out    = state_q;

endmodule

// File: tb/tb_hand_signal_encoder.sv
// Scoreboard bench for hand_signal_encoder: a frame-level reference model queues
// {cycle, code} for each expected strobe; a negedge monitor pops and compares.
module tb_hand_signal_encoder;

  localparam int X_WIDTH       = 11;
  localparam int Y_WIDTH       = 10;
  localparam int DEAD_ZONE     = 16;
  localparam int CLOSE_FRAMES  = 8;
  localparam int REPEAT_FRAMES = 2;
  localparam int W             = 36;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hand_signal_encoder_if #(.X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH)) bus_if ();
  logic [1:0] state_dbg;
`ifdef HAND_SIGNAL_ENCODER_EMIT_COUNT_EN
  logic [15:0] emit_count;
`endif

  hand_signal_encoder #(
    .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .DEAD_ZONE(DEAD_ZONE),
    .CLOSE_FRAMES(CLOSE_FRAMES), .REPEAT_FRAMES(REPEAT_FRAMES)
  ) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .bus          (bus_if),
    .state_dbg_out(state_dbg)
`ifdef HAND_SIGNAL_ENCODER_EMIT_COUNT_EN
    ,
    .emit_count_out(emit_count)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus_if.new_data_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("strobe_pending", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_eq("strobe_cycle", 64'(cyc), 64'(e[W-1:4]));
        check_eq("strobe_code", 64'(bus_if.data_out), 64'(e[3:0]));
      end
    end
  end

  // ---------------- reference model ----------------
  bit m_av;
  int m_ax, m_ay, m_cc, m_rc, m_lc;

  task automatic model_reset();
    m_av = 0; m_ax = 0; m_ay = 0; m_cc = 0; m_rc = 0; m_lc = 0;
  endtask

  task automatic model_frame(input bit v, input int x, input int y, input bit cl,
                             output bit e, output logic [3:0] c);
    int dx, dy, adx, ady, dir;
    e = 0;
    c = 4'd0;
    if (!v) begin
      m_av = 0; m_cc = 0; m_rc = 0;
      if (m_lc != 0) e = 1;
    end else if (!m_av) begin
      m_av = 1; m_ax = x; m_ay = y;
    end else if (cl) begin
      if (m_cc < CLOSE_FRAMES) begin
        m_cc++;
        if (m_cc == CLOSE_FRAMES) begin e = 1; c = 4'd5; end
      end
    end else if (m_cc != 0) begin
      m_cc = 0;
      if (m_lc == 5) e = 1;
    end else begin
      dx  = x - m_ax;
      dy  = y - m_ay;
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      if (adx <= DEAD_ZONE && ady <= DEAD_ZONE) begin
        m_rc = 0;
        if (m_lc >= 1 && m_lc <= 4) e = 1;
      end else begin
        if (adx >= ady) dir = (dx < 0) ? 3 : 4;
        else            dir = (dy < 0) ? 1 : 2;
        if (dir != m_lc || m_rc == 0) begin
          e = 1; c = 4'(dir); m_rc = REPEAT_FRAMES - 1;
        end else begin
          m_rc--;
        end
      end
    end
    if (e) m_lc = int'(c);
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs(input bit v, input int x, input int y, input bit cl);
    bus_if.frame_done_in  = 1'b1;
    bus_if.hand_valid_in  = v;
    bus_if.hand_x_in      = X_WIDTH'(x);
    bus_if.hand_y_in      = Y_WIDTH'(y);
    bus_if.hand_closed_in = cl;
  endtask

  task automatic send_frame(input bit v, input int x, input int y, input bit cl);
    bit e;
    logic [3:0] c;
    @(posedge clk); #1;
    drive_inputs(v, x, y, cl);
    model_frame(v, x, y, cl, e, c);
    if (e) exp_q.push_back({32'(cyc + 2), c});
    @(posedge clk); #1;
    bus_if.frame_done_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic check_hold(input string tag);
    @(negedge clk);
    check_eq(tag, 64'(bus_if.data_out), 64'(m_lc));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.frame_done_in  = 1'b0;
    bus_if.hand_valid_in  = 1'b0;
    bus_if.hand_x_in      = '0;
    bus_if.hand_y_in      = '0;
    bus_if.hand_closed_in = 1'b0;
    model_reset();

    // Reset held with frame_done pulsing
    repeat (3) begin
      @(posedge clk); #1;
      drive_inputs(1'b1, 900, 300, 1'b0);
    end
    @(negedge clk);
    check_eq("rst_new_data", 64'(bus_if.new_data_out), 64'd0);
    check_eq("rst_data", 64'(bus_if.data_out), 64'd0);
    check_eq("rst_overrun", 64'(bus_if.overrun_out), 64'd0);
    check_eq("rst_state", 64'(state_dbg), 64'd0);
    @(posedge clk); #1;
    bus_if.frame_done_in = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_quiet", 64'(bus_if.new_data_out), 64'd0);
    end

    // Right with repeat
    send_frame(1, 100, 100, 0);
    send_frame(1, 130, 105, 0);
    send_frame(1, 130, 105, 0);
    send_frame(1, 130, 105, 0);
    check_hold("hold_right");
    send_frame(0, 0, 0, 0);
    check_hold("hold_lost");

    // Up and return to the dead zone
    send_frame(1, 100, 100, 0);
    send_frame(1, 95, 60, 0);
    send_frame(1, 105, 100, 0);
    send_frame(1, 110, 110, 0);
    send_frame(0, 0, 0, 0);

    // Diagonal tie goes horizontal; dead-zone edge is inclusive
    send_frame(1, 200, 200, 0);
    send_frame(1, 180, 220, 0);
    check_hold("hold_tie_left");
    send_frame(0, 0, 0, 0);
    send_frame(1, 200, 200, 0);
    send_frame(1, 216, 200, 0);
    send_frame(1, 217, 200, 0);
    send_frame(0, 0, 0, 0);

    // Filter gesture, release, move, loss, re-anchor
    send_frame(1, 300, 300, 0);
    for (int i = 0; i < 10; i++) send_frame(1, 300, 300, 1);
    check_hold("hold_filter");
    send_frame(1, 300, 300, 0);
    send_frame(1, 340, 300, 0);
    send_frame(0, 0, 0, 0);
    send_frame(1, 50, 50, 0);
    check_hold("hold_reanchor");
    send_frame(0, 0, 0, 0);

    // Full-range displacements must not wrap
    send_frame(1, 0, 0, 0);
    send_frame(1, 2047, 1023, 0);
    send_frame(0, 0, 0, 0);
    send_frame(1, 2047, 1023, 0);
    send_frame(1, 0, 0, 0);
    send_frame(0, 0, 0, 0);

    // Random frames around a centre point
    for (int i = 0; i < 60; i++) begin
      send_frame($urandom_range(0, 9) != 0, $urandom_range(960, 1040),
                 $urandom_range(460, 540), $urandom_range(0, 3) == 0);
    end
    check_hold("hold_random");

    // Overrun: back-to-back frame_done
    send_frame(0, 0, 0, 0);
    send_frame(1, 500, 500, 0);
    @(negedge clk);
    check_eq("overrun_pre", 64'(bus_if.overrun_out), 64'd0);
    begin
      bit e;
      logic [3:0] c;
      @(posedge clk); #1;
      drive_inputs(1'b1, 600, 500, 1'b0);
      model_frame(1'b1, 600, 500, 1'b0, e, c);
      if (e) exp_q.push_back({32'(cyc + 2), c});
      @(posedge clk); #1;
      drive_inputs(1'b1, 400, 500, 1'b0);
      @(negedge clk);
      check_eq("overrun_t1", 64'(bus_if.overrun_out), 64'd0);
      @(posedge clk); #1;
      bus_if.frame_done_in = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("overrun_sticky", 64'(bus_if.overrun_out), 64'd1);
    end
    check_hold("hold_overrun");

    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_eq("overrun_cleared", 64'(bus_if.overrun_out), 64'd0);
    check_eq("data_cleared", 64'(bus_if.data_out), 64'd0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
